// File: rtl/mux2_arbiter.sv
// Two-requester packet-aware round-robin arbiter driving a 2:1 mux select and a
// single-entry registered output stage with valid/ready on every side.
module mux2_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PKT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_last,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {StArb, StLock1, StLock2} state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               grant_q, grant;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;
  logic               free, arb, acc1, acc2, acc, acc_last;

  assign free = !out_valid_q || out_ready;
  assign arb  = (state_q == StArb);

  // With no request in ARB the select keeps pointing at the last grant.
  always_comb begin
    grant = grant_q;
    case (state_q)
      StArb: begin
        if (in1_valid && in2_valid) grant = prio_q;
        else if (in1_valid)         grant = 1'b1;
        else if (in2_valid)         grant = 1'b0;
      end
      StLock1: grant = 1'b1;
      StLock2: grant = 1'b0;
      default: grant = grant_q;
    endcase
  end

  assign sel       = grant;
  assign in1_ready = rst_n && free && grant && (arb ? in1_valid : 1'b1);
  assign in2_ready = rst_n && free && !grant && (arb ? in2_valid : 1'b1);
  assign acc1      = in1_valid && in1_ready;
  assign acc2      = in2_valid && in2_ready;
  assign acc       = acc1 || acc2;
  assign acc_last  = grant ? in1_last : in2_last;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = grant ? in1_data : in2_data;
      out_last_d  = acc_last;
      out_src_d   = grant;
      if (PKT_MODE != 0) begin
        if (acc_last) begin
          state_d = StArb;
          prio_d  = !grant;
        end else begin
          state_d = grant ? StLock1 : StLock2;
        end
      end else begin
        prio_d = !grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StArb;
      prio_q      <= 1'b1;
      grant_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      grant_q     <= grant;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Random-stimulus bench: one packet-mode and one per-beat instance share the inputs and are
// each compared every cycle against a behavioural model of the arbitration rules.
module tb_mux2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in1_valid, in1_last, in2_valid, in2_last, out_ready;
  logic [31:0] in1_data, in2_data;

  logic        r1 [2];
  logic        r2 [2];
  logic        ov [2];
  logic        ol [2];
  logic        os [2];
  logic        sl [2];
  logic [31:0] od [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: owner 0 = nobody, 1 = in1, 2 = in2; last_g -1 = unknown.
  int          m_owner [2];
  int          m_prio  [2];
  int          m_last_g[2];
  logic        m_ov    [2];
  logic [31:0] m_od    [2];
  logic        m_ol    [2];
  logic        m_os    [2];

  always #5 clk = ~clk;

  mux2_arbiter #(.WIDTH(32), .PKT_MODE(1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(r1[0]),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(r2[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_src(os[0]),
    .out_ready(out_ready), .sel(sl[0])
  );

  mux2_arbiter #(.WIDTH(32), .PKT_MODE(0)) u_beat (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(r1[1]),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(r2[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_src(os[1]),
    .out_ready(out_ready), .sel(sl[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int m);
    m_owner[m]  = 0;
    m_prio[m]   = 1;
    m_last_g[m] = -1;
    m_ov[m]     = 1'b0;
    m_od[m]     = '0;
    m_ol[m]     = 1'b0;
    m_os[m]     = 1'b0;
  endtask

  // Compare instance m against the model for the current inputs, then advance the model
  // by one clock edge.
  task automatic step_model(input int m);
    int   g;
    bit   pkt, free, e1, e2, a1, a2, lst;
    string pfx;
    pkt = (m == 0);
    pfx = pkt ? "pkt" : "beat";
    if (m_owner[m] == 1)                g = 1;
    else if (m_owner[m] == 2)           g = 0;
    else if (in1_valid && in2_valid)    g = m_prio[m];
    else if (in1_valid)                 g = 1;
    else if (in2_valid)                 g = 0;
    else                                g = m_last_g[m];
    free = !m_ov[m] || out_ready;
    e1 = rst_n && free && (g == 1) && (m_owner[m] == 0 ? in1_valid : 1'b1);
    e2 = rst_n && free && (g == 0) && (m_owner[m] == 0 ? in2_valid : 1'b1);
    if (g >= 0) check({pfx, ".sel"}, {31'd0, sl[m]}, g[31:0]);
    check({pfx, ".in1_ready"}, {31'd0, r1[m]}, {31'd0, e1});
    check({pfx, ".in2_ready"}, {31'd0, r2[m]}, {31'd0, e2});
    check({pfx, ".out_valid"}, {31'd0, ov[m]}, {31'd0, m_ov[m]});
    check({pfx, ".out_data"},  od[m], m_od[m]);
    check({pfx, ".out_last"},  {31'd0, ol[m]}, {31'd0, m_ol[m]});
    check({pfx, ".out_src"},   {31'd0, os[m]}, {31'd0, m_os[m]});
    if (!rst_n) begin
      model_reset(m);
      return;
    end
    a1 = in1_valid && e1;
    a2 = in2_valid && e2;
    if (a1 || a2) begin
      lst     = a1 ? in1_last : in2_last;
      m_ov[m] = 1'b1;
      m_od[m] = a1 ? in1_data : in2_data;
      m_ol[m] = lst;
      m_os[m] = a1;
      if (pkt) begin
        m_owner[m] = lst ? 0 : (a1 ? 1 : 2);
        if (lst) m_prio[m] = a1 ? 0 : 1;
      end else begin
        m_prio[m] = a1 ? 0 : 1;
      end
    end else if (out_ready) begin
      m_ov[m] = 1'b0;
    end
    if (g >= 0) m_last_g[m] = g;
  endtask

  task automatic cycle();
    #1;
    step_model(0);
    step_model(1);
    @(negedge clk);
  endtask

  initial begin
    int pv, pl, pr;
    rst_n = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0; in1_last = 1'b0; in2_last = 1'b0;
    in1_data = '0; in2_data = '0; out_ready = 1'b1;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    // Phases vary request density, packet length and downstream backpressure.
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: begin pv = 100; pl = 100; pr = 100; end
        1: begin pv = 90;  pl = 30;  pr = 100; end
        2: begin pv = 80;  pl = 25;  pr = 40;  end
        3: begin pv = 50;  pl = 50;  pr = 70;  end
        default: begin pv = 95; pl = 0; pr = 90; end
      endcase
      for (int c = 0; c < 400; c++) begin
        rst_n     = ($urandom_range(99) >= 2);
        in1_valid = ($urandom_range(99) < pv);
        in2_valid = ($urandom_range(99) < pv);
        in1_last  = ($urandom_range(99) < pl);
        in2_last  = ($urandom_range(99) < pl);
        in1_data  = $urandom;
        in2_data  = $urandom;
        out_ready = ($urandom_range(99) < pr);
        cycle();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Two-requester, packet-aware round-robin arbiter that owns a 2:1 multiplexer on a shared datapath.
- It drives the mux select, and it registers the selected beat into a single-entry output stage with valid/ready handshakes on all three sides.
- It sits in front of any shared downstream consumer that two upstream producers must share beat-by-beat or packet-by-packet.
- Mux convention: sel=1 selects in1, sel=0 selects in2.

Parameters:
- WIDTH, 32, data width of each input and of the output
- PKT_MODE, 1, 1 = hold the grant until the beat with last is accepted; 0 = re-arbitrate every beat (last is passed through only)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- in1_valid  input  1  requester 1 has a beat
- in1_data  input  WIDTH  requester 1 payload
- in1_last  input  1  final beat of a requester 1 packet
- in1_ready  output  1  requester 1 beat accepted this cycle
- in2_valid  input  1  requester 2 has a beat
- in2_data  input  WIDTH  requester 2 payload
- in2_last  input  1  final beat of a requester 2 packet
- in2_ready  output  1  requester 2 beat accepted this cycle
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered payload
- out_last  output  1  registered last flag
- out_src  output  1  1 = beat came from in1, 0 = from in2
- out_ready  input  1  downstream accepts the beat
- sel  output  1  mux select (1 = in1), combinational, equal to the current grant

Behaviour:
- Reset: synchronous, rst_n=0 sampled at a rising edge clears the following.
  - out_valid, out_data, out_last, out_src are all 0.
  - FSM goes to ARB.
  - Round-robin pointer prio=1, so in1 wins the first tie.
  - Reset mid-packet or mid-stall drops the held beat and the lock, with no recovery.
  - in1_ready and in2_ready are 0 while rst_n=0.
- Slot free: free = !out_valid || out_ready, meaning the output register is empty or is draining this cycle.
- Grant is combinational each cycle and depends on the FSM state:
  - ARB:
    - only in1_valid asserted: grant in1
    - only in2_valid asserted: grant in2
    - both asserted: grant per prio (1 = in1, 0 = in2)
    - neither asserted: grant holds its previous value
  - LOCK1: grant is always in1, regardless of in2_valid.
  - LOCK2: grant is always in2, regardless of in1_valid.
- Outputs derived from the grant:
  - sel = grant.
  - in1_ready = free && grant==in1 && (ARB ? in1_valid : 1).
  - in2_ready is symmetric.
  - Accept = inX_valid && inX_ready.
- On accept:
  - The output register loads data, last and src from the mux at the next edge, and out_valid becomes 1.
  - Latency is 1 cycle.
  - Sustained throughput is 1 beat per cycle while out_ready stays at 1.
- When out_valid && out_ready && no accept, out_valid drops to 0 at the next edge.
- When out_valid && !out_ready, the register holds all its fields stable (no overwrite), and both readys are 0.
- FSM transitions (only when PKT_MODE=1; with PKT_MODE=0 the FSM stays in ARB):
  - ARB -> LOCK1: on accept of an in1 beat with in1_last=0.
  - ARB -> LOCK2: on accept of an in2 beat with in2_last=0.
  - LOCK1 -> ARB: on accept of an in1 beat with in1_last=1.
  - LOCK2 -> ARB: on accept of an in2 beat with in2_last=1.
  - In LOCKx with no accept: stay.
- Pointer update:
  - prio is set to the loser of the completed transfer: the accept of a last beat (PKT_MODE=1) or any accept (PKT_MODE=0).
  - Granting in1 sets prio=0; granting in2 sets prio=1.
  - A single-beat packet (last=1 on the first beat) accepted in ARB updates prio and stays in ARB.
- In LOCKx, a deasserted inX_valid leaves a bubble; the other requester still waits.
- Simultaneous drain and load in the same cycle is permitted and is the normal streaming case.

Test Plan:
- Reset, then in1 only, PKT_MODE=1, out_ready=1: in1 sends 3 beats 0xA1,0xA2,0xA3, with last on the third -> out_data A1,A2,A3 on cycles 1,2,3 after the accept, out_src=1, out_last only on A3, sel=1 throughout.
- Both valid from reset, single-beat packets (last=1), out_ready=1 -> grants alternate in1,in2,in1,in2; out_src pattern 1,0,1,0; in1 wins the first beat.
- in1 holds a 4-beat packet while in2_valid=1 from the second beat -> in2_ready stays 0 until the in1 last beat is accepted; the in2 beat follows in the next cycle; no interleaving on out_src.
- Backpressure: out_valid=1 with out_data=0x55 and out_ready=0 for 5 cycles while both inputs are valid -> out_data stays 0x55, in1_ready=in2_ready=0; on out_ready=1, the next beat loads in the same cycle.
- rst_n=0 for 1 cycle in LOCK2 mid-packet with out_valid=1 -> next cycle out_valid=0, FSM in ARB; with both valid, in1 is granted first (prio reset).
- PKT_MODE=0, both valid, last=0 always -> strict per-beat alternation of in1 and in2; the FSM never leaves ARB.
